// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: pipeline-priority access with host starvation guard,
// registered memory command and owner-tracked read-data return.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  I_CLOCK,
    input  logic                  I_LOCK,
    input  logic                  I_PipeReq,
    input  logic                  I_PipeWe,
    input  logic [ADDR_WIDTH-1:0] I_PipeAddr,
    input  logic [DATA_WIDTH-1:0] I_PipeWrData,
    output logic                  O_PipeStall,
    output logic [DATA_WIDTH-1:0] O_PipeRdData,
    output logic                  O_PipeRdValid,
    input  logic                  I_HostReq,
    input  logic                  I_HostWe,
    input  logic [ADDR_WIDTH-1:0] I_HostAddr,
    input  logic [DATA_WIDTH-1:0] I_HostWrData,
    output logic                  O_HostGrant,
    output logic [DATA_WIDTH-1:0] O_HostRdData,
    output logic                  O_HostRdValid,
    output logic                  O_MemEn,
    output logic                  O_MemWe,
    output logic [ADDR_WIDTH-1:0] O_MemAddr,
    output logic [DATA_WIDTH-1:0] O_MemWrData,
    input  logic [DATA_WIDTH-1:0] I_MemRdData
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PIPE_RD = 2'd1,
        HOST_RD = 2'd2,
        WR      = 2'd3
    } owner_t;

    owner_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             cmd_host;
    logic             pipe_wins;
    logic             host_wins;

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        pipe_wins = 1'b0;
        host_wins = 1'b0;
        if (I_LOCK) begin
            pipe_wins = I_PipeReq && !(I_HostReq && (wait_cnt == WAIT_MAX));
            host_wins = I_HostReq && !pipe_wins;
        end
    end

    assign O_PipeStall = I_LOCK & I_PipeReq & ~pipe_wins;
    assign O_HostGrant = host_wins;

    // State follows the command issued on the previous edge, so the owner is
    // known exactly when the memory read data is due.
    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            wait_cnt      <= '0;
            state         <= IDLE;
            cmd_host      <= 1'b0;
            O_MemEn       <= 1'b0;
            O_MemWe       <= 1'b0;
            O_MemAddr     <= '0;
            O_MemWrData   <= '0;
            O_PipeRdData  <= '0;
            O_PipeRdValid <= 1'b0;
            O_HostRdData  <= '0;
            O_HostRdValid <= 1'b0;
        end else begin
            if (!I_HostReq || host_wins) begin
                wait_cnt <= '0;
            end else if (pipe_wins && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            O_MemEn <= pipe_wins | host_wins;
            O_MemWe <= (pipe_wins & I_PipeWe) | (host_wins & I_HostWe);
            if (pipe_wins) begin
                O_MemAddr   <= I_PipeAddr;
                O_MemWrData <= I_PipeWrData;
                cmd_host    <= 1'b0;
            end else if (host_wins) begin
                O_MemAddr   <= I_HostAddr;
                O_MemWrData <= I_HostWrData;
                cmd_host    <= 1'b1;
            end

            if (!O_MemEn) begin
                state <= IDLE;
            end else if (O_MemWe) begin
                state <= WR;
            end else if (cmd_host) begin
                state <= HOST_RD;
            end else begin
                state <= PIPE_RD;
            end

            O_PipeRdValid <= (state == PIPE_RD);
            O_HostRdValid <= (state == HOST_RD);
            if (state == PIPE_RD) begin
                O_PipeRdData <= I_MemRdData;
            end
            if (state == HOST_RD) begin
                O_HostRdData <= I_MemRdData;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          lock;
    logic          pipe_req, pipe_we;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_wd;
    logic          pipe_stall;
    logic [DW-1:0] pipe_rd;
    logic          pipe_rv;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wd;
    logic          host_grant;
    logic [DW-1:0] host_rd;
    logic          host_rv;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
        .I_CLOCK(clk), .I_LOCK(lock),
        .I_PipeReq(pipe_req), .I_PipeWe(pipe_we), .I_PipeAddr(pipe_addr),
        .I_PipeWrData(pipe_wd), .O_PipeStall(pipe_stall),
        .O_PipeRdData(pipe_rd), .O_PipeRdValid(pipe_rv),
        .I_HostReq(host_req), .I_HostWe(host_we), .I_HostAddr(host_addr),
        .I_HostWrData(host_wd), .O_HostGrant(host_grant),
        .O_HostRdData(host_rd), .O_HostRdValid(host_rv),
        .O_MemEn(mem_en), .O_MemWe(mem_we), .O_MemAddr(mem_addr),
        .O_MemWrData(mem_wd), .I_MemRdData(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acts on the command registered at the previous edge.
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wd;
            else        mem_rd <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[10'h3FE] = 16'hBEEF;
        mem_rd    = '0;
        lock      = 1'b0;
        pipe_req  = 1'b1; pipe_we = 1'b1; pipe_addr = 10'h010; pipe_wd = 16'h1234;
        host_req  = 1'b1; host_we = 1'b0; host_addr = 10'h3FE; host_wd = 16'h0000;

        // Reset held with both requests up
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("rst_stall", 32'(pipe_stall), 32'd0);
            chk("rst_grant", 32'(host_grant), 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_pipe_rv", 32'(pipe_rv), 32'd0);
            chk("rst_host_rd", 32'(host_rd), 32'd0);
        end

        // Release: pipe write wins the first edge
        lock = 1'b1;
        #1;
        chk("rel_stall", 32'(pipe_stall), 32'd0);
        chk("rel_grant", 32'(host_grant), 32'd0);
        edge_step();
        chk("wr_mem_en", 32'(mem_en), 32'd1);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h010);
        chk("wr_mem_wd", 32'(mem_wd), 32'h1234);

        // Pipe read of the address just written
        host_req = 1'b0;
        pipe_we  = 1'b0;
        #1;
        chk("rd_stall", 32'(pipe_stall), 32'd0);
        edge_step();
        chk("rd_mem_en", 32'(mem_en), 32'd1);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        pipe_req = 1'b0;
        edge_step();
        chk("rd_n1_rv", 32'(pipe_rv), 32'd0);
        chk("rd_n1_mem_en", 32'(mem_en), 32'd0);
        chk("rd_n1_addr_hold", 32'(mem_addr), 32'h010);
        edge_step();
        chk("rd_n2_rv", 32'(pipe_rv), 32'd1);
        chk("rd_n2_data", 32'(pipe_rd), 32'h1234);
        chk("rd_n2_host_rv", 32'(host_rv), 32'd0);
        edge_step();
        chk("rd_n3_rv", 32'(pipe_rv), 32'd0);

        // Host-only read of preloaded word
        host_req = 1'b1;
        #1;
        chk("h_grant", 32'(host_grant), 32'd1);
        chk("h_stall", 32'(pipe_stall), 32'd0);
        edge_step();
        chk("h_mem_addr", 32'(mem_addr), 32'h3FE);
        chk("h_mem_we", 32'(mem_we), 32'd0);
        host_req = 1'b0;
        edge_step();
        chk("h_n1_rv", 32'(host_rv), 32'd0);
        edge_step();
        chk("h_n2_rv", 32'(host_rv), 32'd1);
        chk("h_n2_data", 32'(host_rd), 32'hBEEF);
        chk("h_n2_pipe_hold", 32'(pipe_rd), 32'h1234);
        chk("h_n2_pipe_rv", 32'(pipe_rv), 32'd0);
        edge_step();
        chk("h_n3_rv", 32'(host_rv), 32'd0);

        // Continuous contention: P,P,P,P,H repeating
        pipe_req = 1'b1;
        host_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("ct_grant_%0d", i), 32'(host_grant), 32'((i % 5) == 4));
            chk($sformatf("ct_stall_%0d", i), 32'(pipe_stall), 32'((i % 5) == 4));
            edge_step();
            chk($sformatf("ct_addr_%0d", i), 32'(mem_addr), ((i % 5) == 4) ? 32'h3FE : 32'h010);
            chk($sformatf("ct_prv_%0d", i), 32'(pipe_rv), 32'((i >= 2) && (((i - 2) % 5) != 4)));
            chk($sformatf("ct_hrv_%0d", i), 32'(host_rv), 32'((i >= 2) && (((i - 2) % 5) == 4)));
        end

        // Host loses twice, drops, re-requests: four more pipe wins needed
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("dr_pre_grant_%0d", i), 32'(host_grant), 32'd0);
            edge_step();
        end
        host_req = 1'b0;
        edge_step();
        host_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("dr_grant_%0d", i), 32'(host_grant), 32'(i == 4));
            chk($sformatf("dr_stall_%0d", i), 32'(pipe_stall), 32'(i == 4));
            edge_step();
        end

        // Reset lands on the edge after a pipe read grant
        host_req = 1'b0;
        edge_step();
        pipe_req = 1'b0;
        edge_step();
        edge_step();
        pipe_req = 1'b1;
        edge_step();
        chk("mr_grant_en", 32'(mem_en), 32'd1);
        pipe_req = 1'b0;
        lock     = 1'b0;
        #1;
        chk("mr_rst_stall", 32'(pipe_stall), 32'd0);
        edge_step();
        chk("mr_n1_rv", 32'(pipe_rv), 32'd0);
        chk("mr_n1_data", 32'(pipe_rd), 32'd0);
        chk("mr_n1_mem_en", 32'(mem_en), 32'd0);
        lock = 1'b1;
        edge_step();
        chk("mr_n2_rv", 32'(pipe_rv), 32'd0);
        chk("mr_n2_data", 32'(pipe_rd), 32'd0);
        edge_step();
        chk("mr_n3_rv", 32'(pipe_rv), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
